logic_unit_bist: RTL and testbench

- Parametrised, registered successor to the team's single-bit and/or/not gates.
- WIDTH-bit bitwise logic unit with 8 selectable ops, valid/ready handshake on input and output, 1-cycle latency.
- Built-in self-test (BIST) sequencer sweeps all op/x/y combinations through the real datapath and checks each result against a golden truth table.
- Used as the standard gate block in later exercises and as a self-checking demo for the simulation flow.

---
 rtl/logic_unit_pkg.sv | 30 +++
 rtl/logic_unit_core.sv | 28 ++
 rtl/logic_unit_bist.sv | 160 ++++++++++++++++
 tb/tb_logic_unit_bist.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the registered bitwise logic unit and its self-test sequencer.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;
    localparam logic [2:0] OP_BUF  = 3'd7;

    localparam int unsigned BIST_VECTORS = 32;
    localparam int unsigned IDX_W        = 5;

    // Nibble n holds the truth table of op n, indexed by {x,y}.
    localparam logic [31:0] GOLDEN = 32'hC96173E8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    function automatic logic golden_bit(input logic [IDX_W-1:0] idx);
        return GOLDEN[idx];
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit bitwise function f(op,x,y); shared by the user path and self-test.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] res_c
);

    always_comb begin
        res_c = '0;
        case (op)
            OP_AND:  res_c = x & y;
            OP_OR:   res_c = x | y;
            OP_NOT:  res_c = ~x;
            OP_NAND: res_c = ~(x & y);
            OP_NOR:  res_c = ~(x | y);
            OP_XOR:  res_c = x ^ y;
            OP_XNOR: res_c = ~(x ^ y);
            OP_BUF:  res_c = x;
            default: res_c = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_bist.sv
// Registered logic unit with valid/ready handshake and a built-in truth-table self-test.
module logic_unit_bist
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter bit          BIST_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    input  logic             fault_inj,
    input  logic             bist_start,
    output logic             bist_busy,
    output logic             bist_done,
    output logic             bist_pass
);

    bist_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
    logic             cmp_vld_q, cmp_vld_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic             idle_c;
    logic             start_req_c;
    logic             start_c;
    logic             accept_c;
    logic             mismatch_c;
    logic [2:0]       core_op_c;
    logic [WIDTH-1:0] core_x_c;
    logic [WIDTH-1:0] core_y_c;
    logic [WIDTH-1:0] core_res_c;
    logic [WIDTH-1:0] result_c;

    assign idle_c      = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign start_req_c = BIST_EN && bist_start;
    assign start_c     = idle_c && start_req_c && !out_valid_q;
    assign in_ready    = idle_c && !start_req_c && (!out_valid_q || out_ready);
    assign accept_c    = in_valid && in_ready;

    // During RUN the counter drives the core instead of the user operands.
    always_comb begin
        core_op_c = op;
        core_x_c  = x;
        core_y_c  = y;
        if (state_q == ST_RUN) begin
            core_op_c = idx_q[4:2];
            core_x_c  = {WIDTH{idx_q[1]}};
            core_y_c  = {WIDTH{idx_q[0]}};
        end
    end

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op    (core_op_c),
        .x     (core_x_c),
        .y     (core_y_c),
        .res_c (core_res_c)
    );

    assign result_c   = core_res_c ^ WIDTH'(fault_inj);
    assign mismatch_c = cmp_vld_q && (out_q != {WIDTH{golden_bit(cmp_idx_q)}});

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cmp_idx_d   = cmp_idx_q;
        cmp_vld_d   = 1'b0;
        err_d       = err_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        if (accept_c) begin
            out_d       = result_c;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (mismatch_c) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_c) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_RUN: begin
                out_d     = result_c;
                cmp_vld_d = 1'b1;
                cmp_idx_d = idx_q;
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(BIST_VECTORS - 1)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = !(err_q || mismatch_c);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cmp_idx_q   <= '0;
            cmp_vld_q   <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmp_idx_q   <= cmp_idx_d;
            cmp_vld_q   <= cmp_vld_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign bist_busy = busy_q;
    assign bist_done = done_q;
    assign bist_pass = pass_q;

endmodule

// File: tb/tb_logic_unit_bist.sv
// Scoreboard bench for logic_unit_bist: handshake, ops, backpressure and self-test sequencing.
module tb_logic_unit_bist;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         fault_inj;
    logic         bist_start;
    logic         bist_busy;
    logic         bist_done;
    logic         bist_pass;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] sb_q[$];

    logic_unit_bist #(.WIDTH(W), .BIST_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .x          (x),
        .y          (y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .fault_inj  (fault_inj),
        .bist_start (bist_start),
        .bist_busy  (bist_busy),
        .bist_done  (bist_done),
        .bist_pass  (bist_pass)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic f);
        logic [W-1:0] r;
        case (o)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = ~a;
            3'd3: r = ~(a & b);
            3'd4: r = ~(a | b);
            3'd5: r = a ^ b;
            3'd6: r = ~(a ^ b);
            default: r = a;
        endcase
        r[0] = r[0] ^ f;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bist_start = 1'b1;
        tick();
        bist_start = 1'b0;
    endtask

    task automatic wait_bist(output int busy_cyc, output bit ov_seen, output bit to);
        busy_cyc = 0;
        ov_seen  = 1'b0;
        to       = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1'b1;
            if (bist_busy) busy_cyc++;
            else if (bist_done) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; op = '0; x = '0; y = '0;
        out_ready = 1'b0; fault_inj = 1'b0; bist_start = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        // load a held result so the asynchronous clear is visible
        op = 3'd1; x = 4'b1100; y = 4'b1010; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out !== 4'b1110) begin
            bad++; $display("FAIL reset_preload out=%h ov=%b expected out=e ov=1", out, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (out !== 4'h0) begin bad++; $display("FAIL reset_out got=%h expected=0", out); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b expected=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b expected=1", in_ready); end
        total++; if (bist_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b expected=0", bist_busy); end
        total++; if (bist_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b expected=0", bist_done); end
        total++; if (bist_pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b expected=0", bist_pass); end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_ops();
        logic [W-1:0] exp_tab [8];
        logic [W-1:0] exp_v;
        int pops = 0;
        exp_tab = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001, 4'b1100};
        out_ready = 1'b1; x = 4'b1100; y = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin in_valid = 1'b1; op = 3'(i); end
            else in_valid = 1'b0;
            @(negedge clk);
            if (i >= 1) begin
                total++;
                if (out_valid !== (i <= 8)) begin
                    bad++; $display("FAIL ops_latency cycle=%0d out_valid=%b expected=%b", i, out_valid, (i <= 8));
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++; $display("FAIL ops_spurious out=%h expected no output", out);
                end else begin
                    exp_v = sb_q.pop_front();
                    pops++;
                    if (out !== exp_v) begin bad++; $display("FAIL ops_result got=%b expected=%b", out, exp_v); end
                end
            end
            if (i < 8) begin
                total++;
                if (in_ready !== 1'b1) begin bad++; $display("FAIL ops_in_ready op=%0d got=%b expected=1", i, in_ready); end
                else sb_q.push_back(exp_tab[i]);
            end
            tick();
        end
        total++;
        if (pops != 8 || sb_q.size() != 0) begin
            bad++; $display("FAIL ops_count pops=%0d left=%0d expected pops=8 left=0", pops, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_v;
        out_ready = 1'b0; op = 3'd0; x = 4'b1100; y = 4'b1010; in_valid = 1'b1;
        @(negedge clk);
        if (in_valid && in_ready) sb_q.push_back(model(op, x, y, 1'b0));
        tick();
        op = 3'd1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (out !== 4'b1000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold cycle=%0d out=%b ov=%b ir=%b expected out=1000 ov=1 ir=0",
                                c, out, out_valid, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b expected=1", in_ready); end
        if (out_valid && out_ready) begin
            exp_v = sb_q.pop_front();
            total++;
            if (out !== exp_v) begin bad++; $display("FAIL bp_first got=%b expected=%b", out, exp_v); end
        end
        if (in_valid && in_ready) sb_q.push_back(model(op, x, y, 1'b0));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (!(out_valid && sb_q.size() == 1)) begin
            bad++; $display("FAIL bp_second_present ov=%b queued=%0d expected ov=1 queued=1", out_valid, sb_q.size());
        end else begin
            exp_v = sb_q.pop_front();
            if (out !== exp_v) begin bad++; $display("FAIL bp_second got=%b expected=%b", out, exp_v); end
        end
        sb_q.delete();
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] exp_v;
        for (int c = 0; c < 100; c++) begin
            if (c < 90) begin
                in_valid  = 1'($urandom_range(0, 1));
                op        = 3'($urandom_range(0, 7));
                x         = W'($urandom);
                y         = W'($urandom);
                fault_inj = ($urandom_range(0, 7) == 0);
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0; fault_inj = 1'b0; out_ready = 1'b1;
            end
            @(negedge clk);
            if (out_valid && out_ready) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++; $display("FAIL rand_spurious out=%h expected no output", out);
                end else begin
                    exp_v = sb_q.pop_front();
                    if (out !== exp_v) begin bad++; $display("FAIL rand_result cycle=%0d got=%h expected=%h", c, out, exp_v); end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model(op, x, y, fault_inj));
            tick();
        end
        total++;
        if (sb_q.size() != 0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rand_drain left=%0d ov=%b expected left=0 ov=0", sb_q.size(), out_valid);
        end
        sb_q.delete();
    endtask

    task automatic test_bist_pass();
        int busy_cyc; bit ov_seen; bit to;
        in_valid = 1'b0; out_ready = 1'b1; fault_inj = 1'b0;
        tick();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL bist_pre_drained ov=%b expected=0", out_valid); end
        pulse_start();
        wait_bist(busy_cyc, ov_seen, to);
        total++; if (to) begin bad++; $display("FAIL bist_pass_timeout busy_cycles=%0d expected done", busy_cyc); end
        total++; if (busy_cyc != 33) begin bad++; $display("FAIL bist_busy_len got=%0d expected=33", busy_cyc); end
        total++; if (ov_seen) begin bad++; $display("FAIL bist_out_valid got=1 expected=0"); end
        total++; if (bist_done !== 1'b1 || bist_pass !== 1'b1) begin
            bad++; $display("FAIL bist_pass_result done=%b pass=%b expected done=1 pass=1", bist_done, bist_pass);
        end
        total++; if (out !== 4'hF) begin bad++; $display("FAIL bist_pass_out got=%h expected=f", out); end
        tick();
        @(negedge clk);
        total++;
        if (bist_done !== 1'b1 || bist_pass !== 1'b1 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bist_sticky done=%b pass=%b ir=%b expected 1 1 1", bist_done, bist_pass, in_ready);
        end
        tick();
    endtask

    task automatic test_bist_fail();
        int busy_cyc; bit ov_seen; bit to;
        fault_inj = 1'b1;
        pulse_start();
        wait_bist(busy_cyc, ov_seen, to);
        fault_inj = 1'b0;
        total++; if (to || busy_cyc != 33) begin
            bad++; $display("FAIL bist_fail_run timeout=%b busy_cycles=%0d expected 0 33", to, busy_cyc);
        end
        total++; if (bist_done !== 1'b1 || bist_pass !== 1'b0) begin
            bad++; $display("FAIL bist_fail_result done=%b pass=%b expected done=1 pass=0", bist_done, bist_pass);
        end
        total++; if (out !== 4'hE) begin bad++; $display("FAIL bist_fail_out got=%h expected=e", out); end
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        total++; if (bist_done !== 1'b0 || bist_pass !== 1'b0 || bist_busy !== 1'b1) begin
            bad++; $display("FAIL bist_restart_clear done=%b pass=%b busy=%b expected 0 0 1", bist_done, bist_pass, bist_busy);
        end
        wait_bist(busy_cyc, ov_seen, to);
        total++; if (to || bist_pass !== 1'b1) begin
            bad++; $display("FAIL bist_rerun_pass timeout=%b pass=%b expected 0 1", to, bist_pass);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        bit busy_seen = 1'b0;
        out_ready = 1'b0; op = 3'd0; x = 4'b1100; y = 4'b1010; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bist_start = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++; $display("FAIL ign_setup ir=%b ov=%b expected ir=0 ov=1", in_ready, out_valid);
        end
        tick();
        bist_start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bist_busy) busy_seen = 1'b1;
            tick();
        end
        total++; if (busy_seen) begin bad++; $display("FAIL ign_busy got=1 expected=0"); end
        total++; if (out_valid !== 1'b1 || out !== 4'b1000) begin
            bad++; $display("FAIL ign_out out=%b ov=%b expected out=1000 ov=1", out, out_valid);
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ign_drain ov=%b expected=0", out_valid); end
        tick();
    endtask

    task automatic test_priority();
        int busy_cyc; bit ov_seen; bit to;
        bist_start = 1'b1; in_valid = 1'b1; op = 3'd1; x = 4'b0101; y = 4'b0011;
        @(negedge clk);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL prio_in_ready got=%b expected=0", in_ready); end
        tick();
        bist_start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        total++; if (bist_busy !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL prio_start busy=%b ov=%b expected busy=1 ov=0", bist_busy, out_valid);
        end
        wait_bist(busy_cyc, ov_seen, to);
        total++; if (to || ov_seen || bist_pass !== 1'b1 || out !== 4'hF) begin
            bad++; $display("FAIL prio_run timeout=%b ov_seen=%b pass=%b out=%h expected 0 0 1 f",
                            to, ov_seen, bist_pass, out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        bit done_seen = 1'b0;
        pulse_start();
        repeat (10) @(negedge clk);
        total++; if (bist_busy !== 1'b1) begin bad++; $display("FAIL abort_running busy=%b expected=1", bist_busy); end
        #2 rst = 1'b1;
        #1;
        total++; if (bist_busy !== 1'b0 || bist_done !== 1'b0 || bist_pass !== 1'b0) begin
            bad++; $display("FAIL abort_clear busy=%b done=%b pass=%b expected 0 0 0", bist_busy, bist_done, bist_pass);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bist_done || bist_busy) done_seen = 1'b1;
        end
        total++; if (done_seen) begin bad++; $display("FAIL abort_no_done got activity expected none"); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_random();
        test_bist_pass();
        test_bist_fail();
        test_start_ignored();
        test_priority();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
